// File: rtl/main_bus_arbiter.sv
// main_bus_arbiter: shares the CPU main bus between pipeline stage 2 and
// NUM_EXT external masters. The pipeline wins every decision point.
// Externals are served round-robin, and each external grant has a bounded
// hold time. One dead turnaround cycle is inserted between owners.
// Optional feature macro: ARB_STARVE_GUARD_EN. When it is defined, the
// pipeline is forced off the bus after STARVE_LIMIT cycles with externals
// waiting.
module main_bus_arbiter #(
  parameter int unsigned NUM_EXT      = 2,
  parameter int unsigned MAX_HOLD     = 8,
  parameter int unsigned STARVE_LIMIT = 16
) (
  input  logic               ClockIn,
  input  logic               Reset,
  input  logic               PipeBusReq,
  input  logic [NUM_EXT-1:0] ExtReq,
  output logic               PipeGrant,
  output logic [NUM_EXT-1:0] ExtGrant,
  output logic               BusBusy,
  output logic               PipeStall,
  output logic               HoldTimeout
);

  localparam int unsigned PW = (NUM_EXT > 1) ? $clog2(NUM_EXT) : 1;
  localparam int unsigned HW = $clog2(MAX_HOLD + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_G_PIPE = 2'd1;
  localparam logic [1:0] S_G_EXT  = 2'd2;
  localparam logic [1:0] S_TURN   = 2'd3;

  logic [1:0]         state_q, state_d;
  logic               pipe_grant_q, pipe_grant_d;
  logic [NUM_EXT-1:0] ext_grant_q, ext_grant_d;
  logic [PW-1:0]      owner_q, owner_d;
  logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [HW-1:0]      hold_cnt_q, hold_cnt_d;
  logic               timeout_q, timeout_d;

  logic               rr_found;
  logic [PW-1:0]      rr_pick;
  logic [NUM_EXT-1:0] rr_onehot;
  logic               owner_req;
  logic [PW-1:0]      owner_next;
  logic               prefer_ext;
  logic               starve_hit;

  assign owner_req  = |(ExtReq & ext_grant_q);
  assign owner_next = (owner_q == PW'(NUM_EXT - 1)) ? '0 : owner_q + PW'(1);

`ifdef ARB_STARVE_GUARD_EN
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] starve_cnt_q, starve_cnt_d;
  logic          prefer_ext_q, prefer_ext_d;

  assign starve_hit = (state_q == S_G_PIPE) && PipeBusReq && (|ExtReq) &&
                      (starve_cnt_q == SW'(STARVE_LIMIT - 1));
  assign prefer_ext = prefer_ext_q;

  // Starvation counter: counts pipeline-owned cycles with externals waiting;
  // reaching the limit arms a one-shot external preference for the next TURN.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    prefer_ext_d = prefer_ext_q;
    if (state_q == S_G_PIPE) begin
      if (!PipeBusReq || starve_hit) begin
        starve_cnt_d = '0;
      end else if (|ExtReq) begin
        starve_cnt_d = starve_cnt_q + SW'(1);
      end
      if (starve_hit) begin
        prefer_ext_d = 1'b1;
      end
    end else begin
      starve_cnt_d = '0;
      prefer_ext_d = '0;
    end
  end

  // Starvation guard registers.
  always_ff @(posedge ClockIn or posedge Reset) begin
    if (Reset) begin
      starve_cnt_q <= '0;
      prefer_ext_q <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      prefer_ext_q <= prefer_ext_d;
    end
  end
`else
  logic unused_starve_limit;
  assign unused_starve_limit = (STARVE_LIMIT == 0);
  assign starve_hit = 1'b0;
  assign prefer_ext = 1'b0;
`endif

  // Round-robin scan: first requesting external at or after rr_ptr, wrapping.
  always_comb begin
    rr_found  = 1'b0;
    rr_pick   = rr_ptr_q;
    rr_onehot = '0;
    for (int unsigned i = 0; i < NUM_EXT; i++) begin
      for (int unsigned j = 0; j < NUM_EXT; j++) begin
        if (!rr_found && ExtReq[j] && (((32'(rr_ptr_q) + i) % NUM_EXT) == j)) begin
          rr_found     = 1'b1;
          rr_pick      = PW'(j);
          rr_onehot    = '0;
          rr_onehot[j] = 1'b1;
        end
      end
    end
  end

  // Next-state logic: decisions in IDLE/TURN, release and hold limit in grant states.
  always_comb begin
    state_d      = state_q;
    pipe_grant_d = pipe_grant_q;
    ext_grant_d  = ext_grant_q;
    owner_d      = owner_q;
    rr_ptr_d     = rr_ptr_q;
    hold_cnt_d   = hold_cnt_q;
    timeout_d    = 1'b0;
    case (state_q)
      S_G_PIPE: begin
        if (!PipeBusReq || starve_hit) begin
          state_d      = S_TURN;
          pipe_grant_d = 1'b0;
        end
      end
      S_G_EXT: begin
        if (!owner_req || (hold_cnt_q == HW'(MAX_HOLD))) begin
          // A same-cycle owner drop counts as a normal release, not a timeout.
          timeout_d   = owner_req;
          state_d     = S_TURN;
          ext_grant_d = '0;
          hold_cnt_d  = '0;
          rr_ptr_d    = owner_next;
        end else begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end
      default: begin
        state_d      = S_IDLE;
        pipe_grant_d = 1'b0;
        ext_grant_d  = '0;
        hold_cnt_d   = '0;
        if (rr_found && (prefer_ext || !PipeBusReq)) begin
          state_d     = S_G_EXT;
          ext_grant_d = rr_onehot;
          owner_d     = rr_pick;
          hold_cnt_d  = HW'(1);
        end else if (PipeBusReq) begin
          state_d      = S_G_PIPE;
          pipe_grant_d = 1'b1;
        end
      end
    endcase
  end

  // Arbiter state registers; reset drops all grants immediately.
  always_ff @(posedge ClockIn or posedge Reset) begin
    if (Reset) begin
      state_q      <= S_IDLE;
      pipe_grant_q <= 1'b0;
      ext_grant_q  <= '0;
      owner_q      <= '0;
      rr_ptr_q     <= '0;
      hold_cnt_q   <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pipe_grant_q <= pipe_grant_d;
      ext_grant_q  <= ext_grant_d;
      owner_q      <= owner_d;
      rr_ptr_q     <= rr_ptr_d;
      hold_cnt_q   <= hold_cnt_d;
      timeout_q    <= timeout_d;
    end
  end

  assign PipeGrant   = pipe_grant_q;
  assign ExtGrant    = ext_grant_q;
  assign BusBusy     = pipe_grant_q | (|ext_grant_q);
  assign PipeStall   = PipeBusReq & ~pipe_grant_q;
  assign HoldTimeout = timeout_q;

endmodule

// File: tb/tb_main_bus_arbiter.sv
// tb_main_bus_arbiter: directed table of per-cycle vectors for
// main_bus_arbiter (NUM_EXT=2, MAX_HOLD=8, STARVE_LIMIT=16), plus
// hand-written sequences for stall bound, async reset and starvation guard.
module tb_main_bus_arbiter;

  logic       ClockIn;
  logic       Reset;
  logic       PipeBusReq;
  logic [1:0] ExtReq;
  logic       PipeGrant;
  logic [1:0] ExtGrant;
  logic       BusBusy;
  logic       PipeStall;
  logic       HoldTimeout;

  int checks;
  int failures;

  main_bus_arbiter #(
    .NUM_EXT     (2),
    .MAX_HOLD    (8),
    .STARVE_LIMIT(16)
  ) dut (
    .ClockIn    (ClockIn),
    .Reset      (Reset),
    .PipeBusReq (PipeBusReq),
    .ExtReq     (ExtReq),
    .PipeGrant  (PipeGrant),
    .ExtGrant   (ExtGrant),
    .BusBusy    (BusBusy),
    .PipeStall  (PipeStall),
    .HoldTimeout(HoldTimeout)
  );

  initial ClockIn = 1'b0;
  always #5 ClockIn = ~ClockIn;

  typedef struct {
    logic       p;
    logic [1:0] e;
    logic       pg;
    logic [1:0] eg;
    logic       to;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic p, input logic [1:0] e, input logic pg,
                     input logic [1:0] eg, input logic to);
    vec_t v;
    v.p = p; v.e = e; v.pg = pg; v.eg = eg; v.to = to;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive inputs on the falling edge, then sample 1 time unit after the rising edge.
  task automatic step(input logic p, input logic [1:0] e);
    @(negedge ClockIn);
    PipeBusReq = p;
    ExtReq     = e;
    @(posedge ClockIn);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int stall_n;
    int to_seen;
    int pg_n;
    bit done;
    checks   = 0;
    failures = 0;

    // Reset held with requests active: nothing granted, pipeline stalled.
    Reset      = 1'b1;
    PipeBusReq = 1'b1;
    ExtReq     = 2'b11;
    @(posedge ClockIn);
    #1;
    check("rst_pipe_grant", int'(PipeGrant), 0);
    check("rst_ext_grant", int'(ExtGrant), 0);
    check("rst_stall", int'(PipeStall), 1);
    check("rst_timeout", int'(HoldTimeout), 0);
    check("rst_busy", int'(BusBusy), 0);
    @(negedge ClockIn);
    Reset = 1'b0;
    @(posedge ClockIn);
    #1;
    check("rst_release_pipe_grant", int'(PipeGrant), 1);
    check("rst_release_stall", int'(PipeStall), 0);

    // Per-cycle vectors: {PipeBusReq, ExtReq} -> {PipeGrant, ExtGrant, HoldTimeout}.
    add(0, 2'b11, 0, 2'b00, 0);                       // pipe release -> TURN
    add(0, 2'b11, 0, 2'b01, 0);                       // ext0, hold 1
    repeat (7) add(0, 2'b11, 0, 2'b01, 0);            // ext0, hold 2..8
    add(0, 2'b11, 0, 2'b00, 1);                       // timeout, TURN
    add(0, 2'b11, 0, 2'b10, 0);                       // ext1, hold 1
    repeat (7) add(0, 2'b11, 0, 2'b10, 0);            // ext1, hold 2..8
    add(0, 2'b11, 0, 2'b00, 1);                       // timeout, TURN
    add(0, 2'b11, 0, 2'b01, 0);                       // ext0 again
    add(1, 2'b11, 0, 2'b01, 0);                       // pipe waits, no preemption
    add(1, 2'b10, 0, 2'b00, 0);                       // ext0 releases -> TURN
    add(1, 2'b10, 1, 2'b00, 0);                       // pipe wins over ext1
    add(1, 2'b10, 1, 2'b00, 0);
    add(0, 2'b10, 0, 2'b00, 0);                       // TURN
    add(0, 2'b10, 0, 2'b10, 0);                       // ext1
    add(0, 2'b00, 0, 2'b00, 0);                       // release -> TURN
    add(0, 2'b00, 0, 2'b00, 0);                       // IDLE
    add(1, 2'b01, 1, 2'b00, 0);                       // simultaneous: pipe first
    add(1, 2'b01, 1, 2'b00, 0);
    add(0, 2'b01, 0, 2'b00, 0);                       // TURN
    add(0, 2'b01, 0, 2'b01, 0);                       // ext0 two cycles after pipe fell
    repeat (7) add(0, 2'b01, 0, 2'b01, 0);            // hold 2..8
    add(0, 2'b00, 0, 2'b00, 0);                       // drop at MAX_HOLD: no timeout
    add(0, 2'b00, 0, 2'b00, 0);                       // IDLE
    add(0, 2'b01, 0, 2'b01, 0);                       // rr_ptr=1 wraps to ext0
    add(0, 2'b11, 0, 2'b01, 0);                       // ext1 request during ext0 grant
    add(0, 2'b00, 0, 2'b00, 0);                       // both drop -> TURN, ext1 never sampled
    add(0, 2'b00, 0, 2'b00, 0);                       // IDLE

    foreach (tbl[k]) begin
      step(tbl[k].p, tbl[k].e);
      check($sformatf("vec%0d_pipe_grant", k), int'(PipeGrant), int'(tbl[k].pg));
      check($sformatf("vec%0d_ext_grant", k), int'(ExtGrant), int'(tbl[k].eg));
      check($sformatf("vec%0d_timeout", k), int'(HoldTimeout), int'(tbl[k].to));
      check($sformatf("vec%0d_stall", k), int'(PipeStall), int'(tbl[k].p & ~tbl[k].pg));
      check($sformatf("vec%0d_busy", k), int'(BusBusy), int'(tbl[k].pg | (|tbl[k].eg)));
    end

    // Pipeline request during a held external grant: stalls through the
    // remaining hold (7 cycles) plus TURN, then gets the bus.
    step(0, 2'b01);
    check("stall_seq_ext0", int'(ExtGrant), 1);
    stall_n = 0;
    to_seen = 0;
    done    = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      step(1, 2'b01);
      if (HoldTimeout) to_seen++;
      if (PipeGrant) done = 1'b1;
      else if (PipeStall) stall_n++;
    end
    check("stall_seq_granted", int'(done), 1);
    check("stall_seq_cycles", stall_n, 8);
    check("stall_seq_timeout_pulses", to_seen, 1);
    check("stall_seq_ext_off", int'(ExtGrant), 0);
    step(0, 2'b00);
    step(0, 2'b00);
    check("stall_seq_idle", int'(BusBusy), 0);

    // Reset mid-grant with rr_ptr=1: grant drops asynchronously, then the
    // first decision after reset scans from 0 with no TURN owed.
    step(0, 2'b10);
    check("rst_mid_ext1", int'(ExtGrant), 2);
    step(0, 2'b10);
    @(negedge ClockIn);
    #2;
    Reset = 1'b1;
    #1;
    check("rst_mid_ext_grant", int'(ExtGrant), 0);
    check("rst_mid_timeout", int'(HoldTimeout), 0);
    check("rst_mid_busy", int'(BusBusy), 0);
    @(negedge ClockIn);
    ExtReq = 2'b11;
    Reset  = 1'b0;
    @(posedge ClockIn);
    #1;
    check("rst_after_rr_ptr0", int'(ExtGrant), 1);
    check("rst_after_timeout", int'(HoldTimeout), 0);

`ifdef ARB_STARVE_GUARD_EN
    // Pipeline held with ext1 waiting: forced off after 16 cycles, ext1 next.
    @(negedge ClockIn);
    Reset = 1'b1;
    @(negedge ClockIn);
    Reset = 1'b0;
    pg_n = 0;
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      step(1, 2'b10);
      if (PipeGrant) pg_n++;
      else done = 1'b1;
    end
    check("starve_pipe_cycles", pg_n, 16);
    check("starve_turn_ext", int'(ExtGrant), 0);
    step(1, 2'b10);
    check("starve_ext1_granted", int'(ExtGrant), 2);
    check("starve_pipe_stall", int'(PipeStall), 1);
`else
    pg_n = 0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
